seg7_scan: RTL

Multiplexed 7-segment display driver. Consumes the slow square wave produced by the clock-divider stage as its scan rate and, on each rising edge of that wave, advances to the next digit. For each digit it drives one active-low anode plus active-low segment and decimal-point lines for a common-anode 4-digit board display. Hex values are latched once per frame, so a digit never shows a mix of old and new data.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/seg7_scan.sv | 104 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned DIGITS_DEFAULT = 4;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode display scanner: advances one digit per rising edge
// of scan_clk and latches display data once per frame on wrap to digit 0.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter  int unsigned DIGITS = DIGITS_DEFAULT,
    localparam int unsigned IDX_W  = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_clk,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [IDX_W-1:0]      digit_idx
);

    logic                  scan_q;
    logic                  tick;
    logic                  wrap;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_next;

    logic [4*DIGITS-1:0]   value_q;
    logic [DIGITS-1:0]     dp_q;
    logic [DIGITS-1:0]     blank_q;

    logic [4*DIGITS-1:0]   value_f;
    logic [DIGITS-1:0]     dp_f;
    logic [DIGITS-1:0]     blank_f;

    logic [3:0]            nibble;
    logic [6:0]            seg_dec;
    logic [DIGITS-1:0]     an_d;

    logic [DIGITS-1:0]     an_q;
    logic [6:0]            seg_q;
    logic                  dpo_q;

    always_comb begin
        tick     = scan_clk & ~scan_q;
        idx_next = idx_q;
        if (tick) begin
            idx_next = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        wrap = tick && (idx_next == '0);

        // Digit 0 of a new frame must already show the data being latched.
        value_f = wrap ? value : value_q;
        dp_f    = wrap ? dp_in : dp_q;
        blank_f = wrap ? blank : blank_q;

        nibble = value_f[4*idx_next +: 4];

        an_d = '1;
        if (en && !blank_f[idx_next]) begin
            an_d[idx_next] = 1'b0;
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_q  <= 1'b0;
            idx_q   <= '0;
            value_q <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
            dpo_q   <= 1'b1;
        end else begin
            scan_q <= scan_clk;
            if (tick) begin
                idx_q <= idx_next;
                if (wrap) begin
                    value_q <= value;
                    dp_q    <= dp_in;
                    blank_q <= blank;
                end
                an_q  <= an_d;
                seg_q <= seg_dec;
                dpo_q <= ~dp_f[idx_next];
            end else if (!en) begin
                // Disable darkens immediately; re-enable waits for the next tick.
                an_q <= '1;
            end
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dpo_q;
    assign digit_idx = idx_q;

endmodule
